// File: rtl/pipeline_sequencer.sv
// Stage/cycle sequencer: walks each instruction through IF, ID, EX, MEM and WB.
// It also handles stall, branch flush, halt/wake and keeps a retired-instruction count.
module pipeline_sequencer #(
    parameter int unsigned STAGE_WIDTH  = 3,
    parameter int unsigned RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    double_fetch,
    input  logic                    double_mem,
    input  logic                    flush,
    input  logic                    halt_req,
    input  logic                    wake,
    output logic [STAGE_WIDTH-1:0]  pipeline_stage,
    output logic                    cycle_count,
    output logic                    fetch_second,
    output logic                    instr_done,
    output logic                    halted,
    output logic [RETIRE_WIDTH-1:0] retired
);

    localparam logic [STAGE_WIDTH-1:0] STAGE_IF  = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STAGE_ID  = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_EX  = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEM = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STAGE_WB  = STAGE_WIDTH'(4);

    logic [STAGE_WIDTH-1:0]  r_stage;
    logic                    r_cycle;
    logic                    r_halted;
    logic [RETIRE_WIDTH-1:0] r_retired;

    logic [STAGE_WIDTH-1:0]  w_stage_d;
    logic                    w_cycle_d;
    logic                    w_halted_d;
    logic                    w_done;
    logic                    w_fetch_second;

    // Completion is masked by stall and never signalled while parked.
    always_comb begin
        w_done = 1'b0;
        if (!r_halted && !stall) begin
            w_done = (r_stage == STAGE_WB) || ((r_stage == STAGE_EX) && flush);
        end
    end

    // Not masked by stall, so a held second-word fetch stays visible.
    assign w_fetch_second = !r_halted && (r_stage == STAGE_ID) && !r_cycle && double_fetch;

    always_comb begin
        w_stage_d  = r_stage;
        w_cycle_d  = r_cycle;
        w_halted_d = r_halted;
        if (r_halted) begin
            if (wake) begin
                w_halted_d = 1'b0;
            end
        end else if (!stall) begin
            case (r_stage)
                STAGE_IF: begin
                    w_stage_d = STAGE_ID;
                    w_cycle_d = 1'b0;
                end
                STAGE_ID: begin
                    if (double_fetch && !r_cycle) begin
                        w_cycle_d = 1'b1;
                    end else begin
                        w_stage_d = STAGE_EX;
                        w_cycle_d = 1'b0;
                    end
                end
                STAGE_EX: begin
                    w_stage_d = flush ? STAGE_IF : STAGE_MEM;
                    w_cycle_d = 1'b0;
                end
                STAGE_MEM: begin
                    if (double_mem && !r_cycle) begin
                        w_cycle_d = 1'b1;
                    end else begin
                        w_stage_d = STAGE_WB;
                        w_cycle_d = 1'b0;
                    end
                end
                STAGE_WB: begin
                    // Parking leaves the stage at IF so wake resumes with a clean fetch.
                    w_stage_d  = STAGE_IF;
                    w_cycle_d  = 1'b0;
                    w_halted_d = halt_req;
                end
                default: begin
                    w_stage_d = STAGE_IF;
                    w_cycle_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage   <= STAGE_IF;
            r_cycle   <= 1'b0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_stage   <= w_stage_d;
            r_cycle   <= w_cycle_d;
            r_halted  <= w_halted_d;
            r_retired <= r_retired + RETIRE_WIDTH'(w_done);
        end
    end

    assign pipeline_stage = r_stage;
    assign cycle_count    = r_cycle;
    assign halted         = r_halted;
    assign retired        = r_retired;
    assign instr_done     = w_done;
    assign fetch_second   = w_fetch_second;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed per-cycle expectations are queued by
// the stimulus process and checked by a separate monitor on the falling clock edge.
module tb_pipeline_sequencer;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    logic        clk = 1'b0;
    logic        reset, stall, double_fetch, double_mem, flush, halt_req, wake;
    logic [2:0]  pipeline_stage, w_stage;
    logic        cycle_count, fetch_second, instr_done, halted;
    logic        w_cycle, w_fs, w_done, w_halted;
    logic [15:0] retired;
    logic [7:0]  w_retired;

    always #5 clk = ~clk;

    pipeline_sequencer u_dut (
        .clk(clk), .reset(reset), .stall(stall), .double_fetch(double_fetch),
        .double_mem(double_mem), .flush(flush), .halt_req(halt_req), .wake(wake),
        .pipeline_stage(pipeline_stage), .cycle_count(cycle_count),
        .fetch_second(fetch_second), .instr_done(instr_done), .halted(halted),
        .retired(retired)
    );

    // Narrow counter instance so the wrap boundary is reachable in a short run.
    pipeline_sequencer #(.RETIRE_WIDTH(8)) u_wrap (
        .clk(clk), .reset(reset), .stall(stall), .double_fetch(double_fetch),
        .double_mem(double_mem), .flush(flush), .halt_req(halt_req), .wake(wake),
        .pipeline_stage(w_stage), .cycle_count(w_cycle),
        .fetch_second(w_fs), .instr_done(w_done), .halted(w_halted),
        .retired(w_retired)
    );

    typedef struct {
        logic [2:0]  stage;
        logic        cyc;
        logic        fs;
        logic        done;
        logic        hlt;
        logic [15:0] ret;
        logic [7:0]  ret_w;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_ret = 0;
    int   n_step = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pipeline_stage", 16'(pipeline_stage), 16'(e.stage));
            chk("cycle_count", 16'(cycle_count), 16'(e.cyc));
            chk("fetch_second", 16'(fetch_second), 16'(e.fs));
            chk("instr_done", 16'(instr_done), 16'(e.done));
            chk("halted", 16'(halted), 16'(e.hlt));
            chk("retired", retired, e.ret);
            chk("retired_wrap8", 16'(w_retired), 16'(e.ret_w));
        end
    end

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic step(input logic st, input logic df, input logic dm, input logic fl,
                        input logic hr, input logic wk, input logic [2:0] e_st,
                        input logic e_cyc, input logic e_fs, input logic e_done,
                        input logic e_hlt);
        exp_t e;
        stall = st; double_fetch = df; double_mem = dm; flush = fl;
        halt_req = hr; wake = wk;
        e.stage = e_st; e.cyc = e_cyc; e.fs = e_fs; e.done = e_done; e.hlt = e_hlt;
        e.ret   = 16'(exp_ret);
        e.ret_w = 8'(exp_ret);
        sb_q.push_back(e);
        if (e_done) exp_ret++;
        n_step++;
        @(posedge clk);
        #1;
    endtask

    task automatic plain_instr();
        step(0, 0, 0, 0, 0, 0, S_IF,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_ID,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_EX,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_MEM, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_WB,  0, 0, 1, 0);
    endtask

    task automatic flush_instr();
        step(0, 0, 0, 1, 0, 0, S_IF, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, S_ID, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, S_EX, 0, 0, 1, 0);
    endtask

    initial begin
        reset = 1'b0; stall = 0; double_fetch = 0; double_mem = 0;
        flush = 0; halt_req = 0; wake = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset held: outputs at reset values regardless of flags.
        step(0, 1, 1, 1, 1, 1, S_IF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_IF, 0, 0, 0, 0);
        reset = 1'b1;

        // Two plain instructions: stages 0..4 twice, done in cycles 5 and 10.
        plain_instr();
        plain_instr();

        // 32-bit instruction: ID held twice, second-word fetch on the first ID cycle.
        step(0, 1, 0, 0, 0, 0, S_IF,  0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_ID,  0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_ID,  1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_EX,  0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_MEM, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_WB,  0, 0, 1, 0);

        // Two-cycle MEM; double_mem ignored in ID and wake ignored while running.
        step(0, 0, 1, 0, 0, 1, S_IF,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, S_ID,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, S_EX,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, S_MEM, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, S_MEM, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, S_WB,  0, 0, 1, 0);

        // 32-bit plus two-cycle MEM: 7 cycles.
        step(0, 1, 1, 0, 0, 0, S_IF,  0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, S_ID,  0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0, S_ID,  1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, S_EX,  0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, S_MEM, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, S_MEM, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, S_WB,  0, 0, 1, 0);

        // Flush in EX: 3-cycle instruction, next is IF.
        flush_instr();

        // Stall beats flush in EX; the flush takes effect the next cycle.
        step(0, 0, 0, 0, 0, 0, S_IF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_ID, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, S_EX, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, S_EX, 0, 0, 1, 0);

        // Stall held 3 cycles in MEM cycle 1, then resume into WB.
        step(0, 0, 1, 0, 0, 0, S_IF,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, S_ID,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, S_EX,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, S_MEM, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, S_MEM, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, S_MEM, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, S_MEM, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, S_MEM, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, S_WB,  0, 0, 1, 0);

        // Stall in the first ID cycle keeps fetch_second asserted.
        step(0, 1, 0, 0, 0, 0, S_IF,  0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, S_ID,  0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_ID,  0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_ID,  1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_EX,  0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_MEM, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_WB,  0, 0, 1, 0);

        // Stall beats halt_req in WB, then halt, frozen 5 cycles, wake.
        step(0, 0, 0, 0, 0, 0, S_IF,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_ID,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_EX,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_MEM, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, S_WB,  0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, S_WB,  0, 0, 1, 0);
        step(0, 1, 1, 1, 1, 0, S_IF,  0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, S_IF,  0, 0, 0, 1);
        step(0, 0, 1, 1, 0, 0, S_IF,  0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 0, S_IF,  0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, S_IF,  0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, S_IF,  0, 0, 0, 1);
        plain_instr();

        // Retire enough flushed instructions to carry the 8-bit counter past 0xFF.
        for (int i = 0; i < 250; i++) begin
            flush_instr();
        end

        // Async reset in MEM: outputs clear before any clock edge.
        step(0, 0, 0, 0, 0, 0, S_IF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_ID, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0, 0);
        reset = 1'b0;
        exp_ret = 0;
        step(0, 0, 1, 0, 0, 0, S_IF, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, S_IF, 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, S_IF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_ID, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Generates the `pipeline_stage` / `cycle_count` pair consumed by `signal_generation_unit`. It walks each instruction through IF → ID → EX → MEM → WB. Extra cycles are inserted for 32-bit instructions (second fetch word in ID) and for two-cycle memory operations (RET, RCALL/CALL stack accesses in MEM). The block also handles stall, branch flush and halt/wake, and keeps a retired-instruction counter. It sits between the instruction decoder and the control-signal generator.

## Interface
- `STAGE_WIDTH`, 3: width of `pipeline_stage`; matches `STAGE_COUNT`.
- `STAGE_IF`/`STAGE_ID`/`STAGE_EX`/`STAGE_MEM`/`STAGE_WB`, 0/1/2/3/4: stage encodings; match `defines.vh`.
- `RETIRE_WIDTH`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  holds the current stage and cycle.
- `double_fetch`  in  1  decoder flag, valid in ID: instruction is 32-bit.
- `double_mem`  in  1  decoder flag, valid in MEM: operation needs two MEM cycles.
- `flush`  in  1  branch taken, valid in EX: abandon MEM/WB.
- `halt_req`  in  1  SLEEP/BREAK decoded, valid in WB.
- `wake`  in  1  leave the halted state.
- `pipeline_stage`  out  STAGE_WIDTH  current stage encoding.
- `cycle_count`  out  1  cycle index within a multi-cycle stage.
- `fetch_second`  out  1  high during the ID cycle that fetches the second word.
- `instr_done`  out  1  one-cycle pulse on the final cycle of an instruction.
- `halted`  out  1  sequencer is parked.
- `retired`  out  RETIRE_WIDTH  count of completed instructions.

## Operation
- State: a stage register, a 1-bit cycle register and a halted flag. Outputs are driven directly from these registers.
- Default transitions, each taken with cycle_count cleared to 0:
  - IF → ID → EX → MEM → WB → IF.
- ID:
  - `double_fetch`=1 and cycle_count=0: stay in ID, cycle_count → 1, `fetch_second`=1 this cycle.
  - Otherwise go to EX.
- EX:
  - `flush`=1: next state is IF, MEM and WB are skipped, `instr_done` pulses this cycle.
- MEM:
  - `double_mem`=1 and cycle_count=0: stay in MEM, cycle_count → 1.
  - Otherwise go to WB.
- WB:
  - `instr_done` pulses.
  - `halt_req`=1: enter halted. Stage reads IF, cycle_count reads 0, `halted`=1.
  - Otherwise go to IF.
- Halted: state is frozen. `wake`=1 clears `halted`; the next cycle is a normal IF.
- Priority (highest first): reset > halted > stall > flush > multi-cycle stay > normal advance.
- `stall` freezes the stage, cycle_count and the counter. `fetch_second` stays asserted while a stall holds it. `instr_done` is masked while `stall`=1.
- `retired` increments by 1 on every unmasked `instr_done`. It wraps modulo 2^RETIRE_WIDTH (0xFFFF → 0x0000) with no saturation.
- Input flags are ignored outside their stated stage. Example: `double_mem` is ignored during ID.

## Timing
- Reset (async assert, synchronous release effect): stage=IF, cycle_count=0, halted=0, `retired`=0, `fetch_second`=0, `instr_done`=0.
- Reset asserted mid-instruction aborts it immediately. The first edge after release advances IF → ID.
- Instruction latency, without stalls:
  - 5 cycles base.
  - +1 with `double_fetch`.
  - +1 with `double_mem`.
  - Flushed instruction: 3 cycles.
- `instr_done` and `fetch_second` are combinational decodes of registered state and the same-cycle inputs. `stall` and `flush` have zero-cycle effect on them.
- Simultaneous cases:
  - `stall`+`flush` in EX: the stall wins and the flush is re-evaluated next cycle.
  - `halt_req`+`stall` in WB: the stall wins.
  - `wake` while not halted: ignored.

## Test plan
- Reset release, no flags, 10 cycles → stage sequence 0,1,2,3,4,0,1,2,3,4; `instr_done` high in cycles 5 and 10; `retired`=2.
- `double_fetch`=1 in ID → ID is held 2 cycles with cycle_count 0 then 1; `fetch_second` is high on the first ID cycle only; instruction takes 6 cycles.
- RET-style `double_mem`=1 → MEM held with cycle_count 0 then 1, then WB; combined with `double_fetch` the instruction takes 7 cycles.
- `flush`=1 in EX → next stage is IF; `instr_done` pulses in EX; MEM/WB are never output; `retired` +1.
- `stall` held 3 cycles in MEM cycle 1 → stage and cycle_count frozen, no `instr_done`; then resumes into WB. Separately: `halt_req` in WB → `halted`=1 and outputs frozen for 5 cycles; `wake` → IF the next cycle.
- Preload `retired`=0xFFFF by retiring 65535 instructions, then one more → `retired`=0x0000. Assert `reset` mid-MEM → all outputs return to reset values asynchronously.
